// File: rtl/mock8080_pkg.sv
// Shared width defaults and loader FSM encoding for the mock 8080 RAM port.
package mock8080_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;
endpackage

// File: rtl/ram_core_256x8.sv
// Byte storage: one write port, registered write-first read(s), 1-cycle latency, no backpressure.
// RAM_DBG_PORT_EN adds a second read port; the array itself is never reset, only the read registers.
module ram_core_256x8 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`ifdef RAM_DBG_PORT_EN
  , input  logic [ADDR_W-1:0] raddr_b
  , output logic [DATA_W-1:0] rdata_b
`endif
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         rdata <= '0;
    else if (we && (waddr == raddr)) rdata <= wdata;
    else                             rdata <= mem[raddr];
  end

`ifdef RAM_DBG_PORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           rdata_b <= '0;
    else if (we && (waddr == raddr_b)) rdata_b <= wdata;
    else                               rdata_b <= mem[raddr_b];
  end
`endif
endmodule

// File: rtl/module_ram_port.sv
// CPU RAM port with a program loader that owns the write port while busy; CPU reads 1-cycle, loader takes a byte per valid in LOAD.
// Optional debug read port under RAM_DBG_PORT_EN; CPU writes are dropped and reads return 0 while busy.
module module_ram_port
  import mock8080_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_qzt,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              busy,
  input  logic              load_abort,
  output logic              load_done
`ifdef RAM_DBG_PORT_EN
  , input  logic [ADDR_W-1:0] dbg_addr
  , output logic [DATA_W-1:0] dbg_data
`endif
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  ld_state_t         state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] remaining, remaining_nxt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_qzt or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      remaining <= remaining_nxt;
    end
  end

  // remaining==0 from load_len means a full wrap: it decrements through 0xFF and stops at 1.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    mem_we        = cpu_we;
    mem_addr      = cpu_addr;
    mem_wdata     = cpu_wdata;
    case (state)
      IDLE: begin
        if (load_start) begin
          ptr_nxt       = load_base;
          remaining_nxt = load_len;
          state_nxt     = LOAD;
        end
      end
      LOAD: begin
        mem_we    = load_valid;
        mem_addr  = ptr;
        mem_wdata = load_data;
        if (load_valid) begin
          ptr_nxt       = ptr + ONE;
          remaining_nxt = remaining - ONE;
          if (remaining == ONE) state_nxt = DONE;
        end
        if (load_abort) state_nxt = IDLE;
      end
      DONE: begin
        mem_we    = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        mem_we    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign load_ready = (state == LOAD);
  assign load_done  = (state == DONE);
  assign cpu_rdata  = busy ? '0 : rd_q;

  ram_core_256x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk   (clk_qzt),
    .rst   (reset),
    .we    (mem_we),
    .waddr (mem_addr),
    .wdata (mem_wdata),
    .raddr (cpu_addr),
    .rdata (rd_q)
`ifdef RAM_DBG_PORT_EN
    , .raddr_b (dbg_addr)
    , .rdata_b (dbg_data)
`endif
  );
endmodule

// File: tb/tb_module_ram_port.sv
// Randomized directed-sequence bench for module_ram_port against an array/counter reference model.
module tb_module_ram_port;
  logic       clk;
  logic       reset;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic [7:0] cpu_rdata;
  logic       load_start;
  logic [7:0] load_base;
  logic [7:0] load_len;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       busy;
  logic       load_abort;
  logic       load_done;
`ifdef RAM_DBG_PORT_EN
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [0:255];

  module_ram_port dut (
    .clk_qzt    (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .busy       (busy),
    .load_abort (load_abort),
    .load_done  (load_done)
`ifdef RAM_DBG_PORT_EN
    , .dbg_addr (dbg_addr)
    , .dbg_data (dbg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sweep(input string tag);
    cpu_we = 1'b0;
    for (int a = 0; a < 256; a++) begin
      cpu_addr = 8'(a);
      step();
      chk(tag, cpu_rdata, mdl[a]);
    end
  endtask

  // Load of len (0 = 256) bytes from base; abort_at>=0 aborts after that many bytes,
  // either together with the last byte (abort_same) or in a following empty cycle.
  task automatic do_load(input logic [7:0] base, input logic [7:0] len, input bit thr,
                         input bit rnd, input int abort_at, input bit abort_same);
    int need, got, pulses;
    logic [7:0] p;
    bit v, ab, fin;
    need = (len == 8'd0) ? 256 : int'(len);
    got = 0; p = base; pulses = 0; fin = 0; ab = 0;
    load_base = base; load_len = len; load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_entry_busy", busy, 1);
    chk("load_entry_ready", load_ready, 1);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      v = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      ab = 1'b0;
      if (abort_at >= 0 && abort_same && got == abort_at - 1) begin
        v = 1'b1; ab = 1'b1;
      end else if (abort_at >= 0 && !abort_same && got == abort_at) begin
        v = 1'b0; ab = 1'b1;
      end
      load_valid = v;
      load_data  = rnd ? 8'($urandom) : 8'((got + 1) * 17);
      load_abort = ab;
      cpu_we     = 1'b1;
      cpu_addr   = (cyc % 2 == 0) ? 8'h40 : 8'($urandom);
      cpu_wdata  = 8'h99;
      load_start = 1'($urandom_range(0, 1));
      step();
      if (v) begin
        mdl[p] = load_data;
        p++;
        got++;
      end
      fin = ab || (got == need);
      if (load_done) pulses++;
      chk("load_busy", busy, !ab);
      chk("load_ready", load_ready, (!ab && got != need));
      chk("load_done_flag", load_done, (!ab && got == need));
      chk("load_rdata", cpu_rdata, ab ? mdl[cpu_addr] : 8'h00);
    end
    chk("load_finished", fin, 1);
    load_valid = 1'b0; load_abort = 1'b0; load_start = 1'b0; cpu_we = 1'b0;
    if (abort_at < 0) begin
      step();
      chk("post_done_busy", busy, 0);
      chk("post_done_pulse", load_done, 0);
      chk("post_done_ready", load_ready, 0);
    end
    chk("load_done_pulses", pulses, (abort_at < 0) ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    load_start = 1'b0; load_base = '0; load_len = '0;
    load_valid = 1'b0; load_data = '0; load_abort = 1'b0;
`ifdef RAM_DBG_PORT_EN
    dbg_addr = '0;
`endif
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_rdata", cpu_rdata, 0);
    reset = 1'b0;
    step();

    for (int a = 0; a < 256; a++) begin
      cpu_we = 1'b1; cpu_addr = 8'(a); cpu_wdata = 8'($urandom);
      step();
      mdl[a] = cpu_wdata;
    end
    cpu_we = 1'b0;

    // Single write then read back, plus write-first visibility in the write cycle.
    cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    step();
    mdl[8'h10] = 8'hA5;
    chk("wr_first", cpu_rdata, mdl[8'h10]);
    cpu_we = 1'b0;
    step();
    chk("wr_then_rd", cpu_rdata, mdl[8'h10]);

    for (int i = 0; i < 300; i++) begin
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      cpu_wdata = 8'($urandom);
      step();
      if (cpu_we) mdl[cpu_addr] = cpu_wdata;
      chk("rand_cpu", cpu_rdata, mdl[cpu_addr]);
    end
    cpu_we = 1'b0;

    do_load(8'hFE, 8'd3, 1'b0, 1'b0, -1, 1'b0);
    sweep("sweep_wrap_load");

    do_load(8'h30, 8'd4, 1'b0, 1'b1, 2, 1'b0);
    sweep("sweep_abort");

    do_load(8'h50, 8'd5, 1'b0, 1'b1, 3, 1'b1);
    sweep("sweep_abort_same");

    do_load(8'($urandom), 8'd0, 1'b1, 1'b1, -1, 1'b0);
    sweep("sweep_full_load");

    // Reset mid-load after one byte.
    load_base = 8'h80; load_len = 8'd4; load_start = 1'b1;
    step();
    load_start = 1'b0; load_valid = 1'b1; load_data = 8'h5C;
    step();
    mdl[8'h80] = 8'h5C;
    load_valid = 1'b0;
    chk("midrst_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", load_ready, 0);
    chk("midrst_done", load_done, 0);
    chk("midrst_rdata", cpu_rdata, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk("midrst_idle", busy, 0);
    sweep("sweep_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/module_ram_port.md
MODULE_RAM_PORT -- requirements
Module: module_ram_port

Interface
REQ-001 Parameter ADDR_W, 8, address width; memory depth is 2**ADDR_W bytes.
REQ-002 Parameter DATA_W, 8, data width of every byte lane.
REQ-003 Port clk_qzt  input  1  single system clock; all logic is rising-edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port cpu_addr  input  ADDR_W  CPU bus address (driven by CPU data_addr).
REQ-006 Port cpu_wdata  input  DATA_W  CPU write data (driven by CPU data_out).
REQ-007 Port cpu_we  input  1  CPU write enable, level-sensitive.
REQ-008 Port cpu_rdata  output  DATA_W  read data returned to CPU data_in.
REQ-009 Port load_start  input  1  one-cycle request to begin a program load.
REQ-010 Port load_base  input  ADDR_W  first address written by the loader.
REQ-011 Port load_len  input  ADDR_W  byte count; 0 means 2**ADDR_W.
REQ-012 Port load_valid / load_data  input  1 / DATA_W  loader byte stream.
REQ-013 Port load_ready  output  1  loader accepts a byte this cycle.
REQ-014 Port busy  output  1  loader owns memory; CPU enable is held low while it is high.
REQ-015 Port load_abort  input  1  terminates an active load.
REQ-016 Port load_done  output  1  one-cycle pulse on successful completion.

Function
REQ-017 CPU read: cpu_rdata SHALL equal mem[cpu_addr] sampled on the previous clk_qzt edge (1-cycle latency).
REQ-018 CPU write: on each edge with cpu_we=1 and busy=0, mem[cpu_addr] SHALL be written with cpu_wdata; repeated writes while cpu_we is held are idempotent.
REQ-019 Same-address read during a write SHALL return the new data (write-first).
REQ-020 FSM states: IDLE, LOAD, DONE; load_start SHALL be ignored outside IDLE.
REQ-021 IDLE + load_start: the FSM SHALL capture load_base into ptr and load_len into remaining, then enter LOAD on the next edge.
REQ-022 LOAD: load_ready=1 and busy=1; each edge with load_valid=1 SHALL write load_data to mem[ptr], then increment ptr (wraps 0xFF->0x00) and decrement remaining.
REQ-023 When the byte with remaining=1 is accepted, the FSM SHALL enter DONE; DONE asserts load_done for exactly one cycle, then returns to IDLE.
REQ-024 load_abort in LOAD SHALL return the FSM to IDLE on the next edge without a load_done pulse; bytes already written remain; abort in the same cycle as a valid byte writes that byte first.
REQ-025 While busy=1, cpu_we SHALL be ignored and cpu_rdata SHALL read 0x00.
REQ-026 busy SHALL be 1 in LOAD and DONE and 0 in IDLE.

Reset
REQ-027 Asserting reset SHALL immediately force FSM=IDLE, cpu_rdata=0x00, load_ready=0, busy=0, load_done=0, ptr=0, and remaining=0, including when a load is in progress.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro RAM_DBG_PORT_EN: when defined, the block SHALL add input dbg_addr[ADDR_W] and output dbg_data[DATA_W]. dbg_data = mem[dbg_addr] with 1-cycle latency, independent of busy, and reset to 0x00.
REQ-030 Without RAM_DBG_PORT_EN, neither debug port nor the second read path SHALL exist.

Structure
REQ-031 A shared package mock8080_pkg SHALL hold ADDR_W/DATA_W defaults and the loader state encoding (IDLE=0, LOAD=1, DONE=2).
REQ-032 Storage SHALL be a sub-module ram_core_256x8: one write port, plus one read port or two read ports under RAM_DBG_PORT_EN. The FSM and arbitration reside in module_ram_port.

Verification
REQ-033 Write then read: cpu_we=1, addr 0x10, wdata 0xA5 for one cycle; then addr 0x10 -> cpu_rdata=0xA5 one cycle later.
REQ-034 Load: base 0xFE, len 3, bytes 0x11,0x22,0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33; load_done pulses once; busy falls the cycle after.
REQ-035 Blocking: during a load, cpu_we=1 at addr 0x40 with wdata 0x99 -> mem[0x40] is unchanged and cpu_rdata=0x00.
REQ-036 Abort: len 4, two bytes sent, then load_abort -> FSM is IDLE, no load_done, and the two bytes are present.
REQ-037 Mid-load reset: reset asserted after one byte -> busy=0 and load_ready=0 immediately, and the written byte is retained.
REQ-038 len=0: 256 bytes with valid throttled 50% -> exactly 256 writes, then load_done; load_start is ignored while busy.
